obstacle_manager: RTL and testbench



---
 rtl/game_pkg.sv | 19 +
 rtl/lfsr16.sv | 25 ++
 rtl/obstacle_manager.sv | 136 +++++++++++++
 tb/tb_obstacle_manager.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared side-scroller game constants and types.
// Used by obstacle_manager, vga_screen_pic and the collision checker.
package game_pkg;

  typedef enum logic [1:0] {
    GM_INITIAL = 2'b00,
    GM_INGAME  = 2'b01,
    GM_PAUSED  = 2'b10,
    GM_ENDED   = 2'b11
  } gamemode_t;

  localparam int NUM_OBS     = 10;
  localparam int SCREEN_W    = 640;
  localparam int UPPER_BOUND = 20;
  localparam int LOWER_BOUND = 460;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left.
// Advances only when en is high; never reaches zero from a nonzero seed.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  // shift register with feedback entering at bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/obstacle_manager.sv
// Owns the obstacle slots: scrolls, retires and spawns them once per frame.
// Inactive slots hold all-zero coordinates so the drawer sees empty boxes.
module obstacle_manager #(
  parameter int NUM_OBS        = game_pkg::NUM_OBS,
  parameter int SPEED          = 2,
  parameter int SPAWN_INTERVAL = 90,
  parameter int OBS_WIDTH      = 40,
  parameter int SCREEN_W       = game_pkg::SCREEN_W,
  parameter int UPPER_BOUND    = game_pkg::UPPER_BOUND,
  parameter int LOWER_BOUND    = game_pkg::LOWER_BOUND,
  parameter int MIN_H          = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         gamemode,
  input  logic               frame_tick,
  output logic [9:0]         obstacle_x_game_left  [NUM_OBS],
  output logic [9:0]         obstacle_x_game_right [NUM_OBS],
  output logic [8:0]         obstacle_y_game_up    [NUM_OBS],
  output logic [8:0]         obstacle_y_game_down  [NUM_OBS],
  output logic [NUM_OBS-1:0] active
);

  localparam logic [9:0] SPD  = 10'(SPEED);
  localparam logic [9:0] SP_L = 10'(SCREEN_W);
  localparam logic [9:0] SP_R = 10'(SCREEN_W + OBS_WIDTH);
  localparam logic [6:0] LAST = 7'(SPAWN_INTERVAL - 1);

  game_pkg::gamemode_t gm;
  logic               clear;
  logic               tick;
  logic               spawn;
  logic               free_any;
  logic [NUM_OBS-1:0] act;
  logic [NUM_OBS-1:0] sel;
  logic [6:0]         spawn_cnt;
  logic [15:0]        rnd;
  logic [8:0]         h;
  logic [8:0]         sp_up;
  logic [8:0]         sp_down;
  logic               unused_rnd;

  assign gm         = game_pkg::gamemode_t'(gamemode);
  assign clear      = (gm == game_pkg::GM_INITIAL);
  assign tick       = (gm == game_pkg::GM_INGAME) && frame_tick;
  assign spawn      = tick && (spawn_cnt == LAST) && free_any;
  assign active     = act;
  assign unused_rnd = ^rnd[15:8];

  lfsr16 #(
    .SEED (game_pkg::LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (spawn),
    .q   (rnd)
  );

  // lowest free slot, judged on the mask from before this tick
  always_comb begin
    sel      = '0;
    free_any = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!act[i] && !free_any) begin
        sel[i]   = 1'b1;
        free_any = 1'b1;
      end
    end
  end

  // spawn geometry from the current LFSR value
  always_comb begin
    h = 9'(MIN_H) + 9'(rnd[6:0]);
    if (rnd[7]) begin
      sp_up   = 9'(LOWER_BOUND) - h;
      sp_down = 9'(LOWER_BOUND);
    end else begin
      sp_up   = 9'(UPPER_BOUND + 1);
      sp_down = 9'(UPPER_BOUND + 1) + h;
    end
  end

  // frame counter pacing spawn attempts; wraps even if spawn is dropped
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      spawn_cnt <= '0;
    end else if (tick) begin
      spawn_cnt <= (spawn_cnt == LAST) ? '0 : spawn_cnt + 7'd1;
    end
  end

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
    logic       v;
    logic [9:0] l;
    logic [9:0] r;
    logic [8:0] u;
    logic [8:0] d;

    // per-slot spawn landing, scroll with saturating left, retire
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        v <= 1'b0;
        l <= '0;
        r <= '0;
        u <= '0;
        d <= '0;
      end else if (tick) begin
        if (spawn && sel[i]) begin
          v <= 1'b1;
          l <= SP_L;
          r <= SP_R;
          u <= sp_up;
          d <= sp_down;
        end else if (v) begin
          if (r <= SPD) begin
            v <= 1'b0;
            l <= '0;
            r <= '0;
            u <= '0;
            d <= '0;
          end else begin
            r <= r - SPD;
            l <= (l >= SPD) ? l - SPD : '0;
          end
        end
      end
    end

    assign act[i]                   = v;
    assign obstacle_x_game_left[i]  = l;
    assign obstacle_x_game_right[i] = r;
    assign obstacle_y_game_up[i]    = u;
    assign obstacle_y_game_down[i]  = d;
  end

endmodule

// File: tb/tb_obstacle_manager.sv
// Scoreboard bench for obstacle_manager: default instance plus a
// fast-spawn, zero-speed instance for the slot-full case.
module tb_obstacle_manager;
  import game_pkg::*;

  localparam int N  = 10;
  localparam int SW = 39;
  localparam int FW = N * SW;

  typedef struct {
    string          name;
    int             dut;
    logic [FW-1:0]  exp;
    logic [FW-1:0]  msk;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic [1:0] gm_a  = 2'b00;
  logic       ft_a  = 1'b0;
  logic [9:0] la [N];
  logic [9:0] ra [N];
  logic [8:0] ua [N];
  logic [8:0] da [N];
  logic [N-1:0] act_a;

  logic       rst_b = 1'b1;
  logic [1:0] gm_b  = 2'b00;
  logic       ft_b  = 1'b0;
  logic [9:0] lb [N];
  logic [9:0] rb [N];
  logic [8:0] ub [N];
  logic [8:0] db [N];
  logic [N-1:0] act_b;

  logic [FW-1:0] flat_a;
  logic [FW-1:0] flat_b;

  item_t sbq [$];
  item_t mon_it;
  logic [FW-1:0] mon_act;
  int checks = 0;
  int errors = 0;

  obstacle_manager u_a (
    .clk                   (clk),
    .rst                   (rst_a),
    .gamemode              (gm_a),
    .frame_tick            (ft_a),
    .obstacle_x_game_left  (la),
    .obstacle_x_game_right (ra),
    .obstacle_y_game_up    (ua),
    .obstacle_y_game_down  (da),
    .active                (act_a)
  );

  obstacle_manager #(
    .SPEED          (0),
    .SPAWN_INTERVAL (1)
  ) u_b (
    .clk                   (clk),
    .rst                   (rst_b),
    .gamemode              (gm_b),
    .frame_tick            (ft_b),
    .obstacle_x_game_left  (lb),
    .obstacle_x_game_right (rb),
    .obstacle_y_game_up    (ub),
    .obstacle_y_game_down  (db),
    .active                (act_b)
  );

  always_comb begin
    flat_a = '0;
    flat_b = '0;
    for (int i = 0; i < N; i++) begin
      flat_a[i*SW +: SW] = {act_a[i], la[i], ra[i], ua[i], da[i]};
      flat_b[i*SW +: SW] = {act_b[i], lb[i], rb[i], ub[i], db[i]};
    end
  end

  function automatic logic [SW-1:0] box(int l, int r, int u, int d);
    return {1'b1, 10'(l), 10'(r), 9'(u), 9'(d)};
  endfunction

  function automatic logic [FW-1:0] put(logic [FW-1:0] v, int i,
                                        logic [SW-1:0] s);
    v[i*SW +: SW] = s;
    return v;
  endfunction

  function automatic logic [FW-1:0] smask(int i);
    logic [FW-1:0] z;
    z = '0;
    z[i*SW +: SW] = '1;
    return z;
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    logic fb;
    fb = v[16-1] ^ v[14-1] ^ v[13-1] ^ v[11-1];
    return {v[14:0], fb};
  endfunction

  function automatic logic [SW-1:0] spawn_box(logic [15:0] v);
    int hh;
    hh = 40 + int'(v[6:0]);
    if (v[7]) return box(640, 680, 460 - hh, 460);
    return box(640, 680, 21, 21 + hh);
  endfunction

  task automatic expect_st(string n, int dut, logic [FW-1:0] e,
                           logic [FW-1:0] m);
    item_t it;
    it.name = n;
    it.dut  = dut;
    it.exp  = e;
    it.msk  = m;
    sbq.push_back(it);
  endtask

  task automatic ticks_a(int n);
    repeat (n) begin
      @(negedge clk) ft_a = 1'b1;
      @(negedge clk) ft_a = 1'b0;
    end
  endtask

  task automatic ticks_b(int n);
    repeat (n) begin
      @(negedge clk) ft_b = 1'b1;
      @(negedge clk) ft_b = 1'b0;
    end
  endtask

  // monitor: compare queued expectations just after each rising edge
  always @(posedge clk) begin
    #2;
    while (sbq.size() > 0) begin
      mon_it  = sbq.pop_front();
      mon_act = (mon_it.dut == 0) ? flat_a : flat_b;
      checks++;
      if ((mon_act & mon_it.msk) !== (mon_it.exp & mon_it.msk)) begin
        errors++;
        $display("FAIL %s dut%0d got %h want %h", mon_it.name,
                 mon_it.dut, mon_act & mon_it.msk,
                 mon_it.exp & mon_it.msk);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] all;
    logic [FW-1:0] e;
    logic [FW-1:0] bit38;
    logic [15:0]   v;

    all   = '1;
    bit38 = '0;
    bit38[38] = 1'b1;

    repeat (2) @(negedge clk);
    expect_st("reset", 0, '0, all);
    @(negedge clk);
    rst_a = 1'b0;
    gm_a  = GM_INGAME;

    ticks_a(89);
    expect_st("pre_spawn", 0, '0, all);

    ticks_a(1);
    e = put('0, 0, box(640, 680, 323, 460));
    expect_st("spawn0", 0, e, all);

    ticks_a(1);
    e = put('0, 0, box(638, 678, 323, 460));
    expect_st("move1", 0, e, all);

    @(negedge clk) gm_a = GM_PAUSED;
    ticks_a(50);
    expect_st("pause", 0, e, all);

    @(negedge clk) gm_a = GM_INGAME;
    ticks_a(88);
    e = put('0, 0, box(462, 502, 323, 460));
    expect_st("resume_pre", 0, e, all);

    ticks_a(1);
    e = put('0, 0, box(460, 500, 323, 460));
    e = put(e, 1, box(640, 680, 353, 460));
    expect_st("spawn1", 0, e, all);

    ticks_a(249);
    e = put('0, 0, box(0, 2, 323, 460));
    e = put(e, 1, box(142, 182, 353, 460));
    e = put(e, 2, box(322, 362, 413, 460));
    e = put(e, 3, box(502, 542, 21, 76));
    expect_st("pre_retire", 0, e, all);

    ticks_a(1);
    expect_st("retire", 0, '0, smask(0));

    ticks_a(20);
    e = put('0, 0, box(640, 680, 21, 91));
    expect_st("respawn", 0, e, smask(0));

    @(negedge clk) gm_a = GM_ENDED;
    ticks_a(10);
    expect_st("ended_freeze", 0, e, smask(0));

    @(negedge clk);
    gm_a = GM_INITIAL;
    expect_st("gm00_clear", 0, '0, all);

    @(negedge clk) gm_a = GM_INGAME;
    ticks_a(90);
    expect_st("mid_active", 0, bit38, bit38);

    @(negedge clk);
    rst_a = 1'b1;
    ft_a  = 1'b1;
    expect_st("rst_wins", 0, '0, all);
    @(negedge clk);
    rst_a = 1'b0;
    ft_a  = 1'b0;

    ticks_a(90);
    e = put('0, 0, box(640, 680, 323, 460));
    expect_st("reseed", 0, e, all);

    @(negedge clk) rst_b = 1'b0;
    gm_b = GM_INGAME;
    ticks_b(10);
    e = '0;
    v = 16'hACE1;
    for (int i = 0; i < N; i++) begin
      e = put(e, i, spawn_box(v));
      v = lfsr_next(v);
    end
    expect_st("fill", 1, e, all);

    ticks_b(1);
    expect_st("drop", 1, e, all);

    @(negedge clk);
    gm_b = GM_INITIAL;
    expect_st("b_clear", 1, '0, all);

    @(negedge clk) gm_b = GM_INGAME;
    ticks_b(1);
    e = put('0, 0, spawn_box(v));
    expect_st("lfsr_hold", 1, e, all);

    repeat (5) @(posedge clk);
    #3;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
